// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: turns keypad click strobes into decimal operands A/B,
// launches the ALU with a start/done handshake and selects the value shown on screen.
module calc_entry_sequencer #(
    parameter int DATA_W      = 16,
    parameter int MAX_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              newDigit,
    input  logic              newOp,
    input  logic [3:0]        clickedMatrix,
    input  logic              clear,
    output logic              alu_start,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_err,
    output logic [DATA_W-1:0] display_value,
    output logic              error,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_EQUALS = 4'd14;

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_OP_WAIT,
        S_ENTER_B,
        S_EXEC,
        S_RESULT
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              start_q, start_d;
    logic              error_q, error_d;
    logic              prev_q, prev_d;

    logic              click;
    logic              click_ev;
    logic              digit_ev;
    logic              op_ev;
    logic              equals_ev;
    logic [DATA_W-1:0] digit_val;

    // X*10 + d, wrapping at DATA_W bits.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] d);
        return (x << 3) + (x << 1) + d;
    endfunction

    // Buttons are levels held for many cycles; only the press edge is an event,
    // and a simultaneous digit+op press resolves to the digit.
    assign click     = newDigit | newOp;
    assign click_ev  = click & ~prev_q;
    assign digit_ev  = click_ev & newDigit & (clickedMatrix <= 4'd9);
    assign op_ev     = click_ev & ~newDigit & (clickedMatrix >= 4'd1) & (clickedMatrix <= 4'd4);
    assign equals_ev = click_ev & ~newDigit & (clickedMatrix == OP_EQUALS);
    assign digit_val = DATA_W'(clickedMatrix);

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        tmo_d    = tmo_q;
        error_d  = error_q;
        start_d  = 1'b0;
        prev_d   = click;

        if (clear) begin
            state_d  = S_ENTER_A;
            a_d      = '0;
            b_d      = '0;
            result_d = '0;
            cnt_d    = '0;
            op_d     = '0;
            tmo_d    = '0;
            error_d  = 1'b0;
            prev_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_ENTER_A: begin
                    if (digit_ev) begin
                        if (cnt_q < CNT_MAX) begin
                            a_d   = shift_in(a_q, digit_val);
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (op_ev) begin
                        op_d = clickedMatrix;
                        if (cnt_q == '0) begin
                            a_d = '0;
                        end
                        state_d = S_OP_WAIT;
                    end
                end

                S_OP_WAIT: begin
                    if (digit_ev) begin
                        b_d     = digit_val;
                        cnt_d   = CNT_ONE;
                        state_d = S_ENTER_B;
                    end else if (op_ev) begin
                        op_d = clickedMatrix;
                    end
                end

                S_ENTER_B: begin
                    if (digit_ev) begin
                        if (cnt_q < CNT_MAX) begin
                            b_d   = shift_in(b_q, digit_val);
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (op_ev) begin
                        op_d = clickedMatrix;
                    end else if (equals_ev) begin
                        // Divide by zero is caught here so the ALU is never launched on it.
                        if (op_q == OP_DIV && b_q == '0) begin
                            error_d  = 1'b1;
                            result_d = '0;
                            state_d  = S_RESULT;
                        end else begin
                            start_d = 1'b1;
                            tmo_d   = '0;
                            state_d = S_EXEC;
                        end
                    end
                end

                S_EXEC: begin
                    if (alu_done) begin
                        result_d = alu_result;
                        error_d  = alu_err;
                        state_d  = S_RESULT;
                    end else if (tmo_q == TMO_LAST) begin
                        result_d = '0;
                        error_d  = 1'b1;
                        state_d  = S_RESULT;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end

                S_RESULT: begin
                    if (digit_ev) begin
                        a_d     = digit_val;
                        cnt_d   = CNT_ONE;
                        b_d     = '0;
                        error_d = 1'b0;
                        state_d = S_ENTER_A;
                    end else if (op_ev) begin
                        a_d     = result_q;
                        error_d = 1'b0;
                        op_d    = clickedMatrix;
                        state_d = S_OP_WAIT;
                    end
                end

                default: state_d = S_ENTER_A;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ENTER_A;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            tmo_q    <= '0;
            start_q  <= 1'b0;
            error_q  <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            tmo_q    <= tmo_d;
            start_q  <= start_d;
            error_q  <= error_d;
            prev_q   <= prev_d;
        end
    end

    always_comb begin
        unique case (state_q)
            S_ENTER_B, S_EXEC: display_value = b_q;
            S_RESULT:          display_value = result_q;
            default:           display_value = a_q;
        endcase
    end

    assign alu_start = start_q;
    assign alu_op    = op_q;
    assign operand_a = a_q;
    assign operand_b = b_q;
    assign error     = error_q;
    assign busy      = (state_q == S_EXEC);

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Self-checking bench for calc_entry_sequencer: directed scenarios plus random key
// sequences compared against an event-level calculator model and a behavioural ALU.
module tb_calc_entry_sequencer;

    localparam int DW   = 16;
    localparam int MD   = 4;
    localparam int TMO  = 1024;
    localparam int MASK = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          newDigit, newOp, clear;
    logic [3:0]    clickedMatrix;
    logic          alu_start, alu_done, alu_err, error, busy;
    logic [3:0]    alu_op;
    logic [DW-1:0] operand_a, operand_b, alu_result, display_value;

    always #5 clk = ~clk;

    calc_entry_sequencer #(.DATA_W(DW), .MAX_DIGITS(MD), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .newDigit(newDigit), .newOp(newOp),
        .clickedMatrix(clickedMatrix), .clear(clear), .alu_start(alu_start),
        .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .display_value(display_value), .error(error), .busy(busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Calculator as a user sees it: which operand is being typed, and the values.
    typedef enum {PH_A, PH_OPW, PH_B, PH_RES} phase_e;
    phase_e m_ph;
    int     m_a, m_b, m_res, m_na, m_nb, m_op;
    bit     m_err;

    function automatic void m_reset();
        m_ph = PH_A; m_a = 0; m_b = 0; m_res = 0; m_na = 0; m_nb = 0; m_op = 0; m_err = 0;
    endfunction

    function automatic int m_disp();
        case (m_ph)
            PH_B:    return m_b;
            PH_RES:  return m_res;
            default: return m_a;
        endcase
    endfunction

    function automatic void alu_ref(input int a, input int b, input int op,
                                    output int r, output bit e);
        longint p;
        r = 0; e = 0; p = 0;
        case (op)
            1: begin p = longint'(a) * b; e = (p > MASK); r = int'(p & MASK); end
            2: begin p = longint'(a) + b; e = (p > MASK); r = int'(p & MASK); end
            3: begin e = (b > a); r = (a - b) & MASK; end
            4: begin e = (b == 0); r = (b == 0) ? 0 : a / b; end
            default: ;
        endcase
    endfunction

    // Applies one key press to the model; returns 1 when an ALU launch is expected.
    function automatic bit m_event(input bit dig, input bit op, input int code);
        bit launch = 0;
        if (dig) begin
            if (code <= 9) begin
                case (m_ph)
                    PH_A:   if (m_na < MD) begin m_a = (m_a * 10 + code) % (MASK + 1); m_na++; end
                    PH_OPW: begin m_b = code; m_nb = 1; m_ph = PH_B; end
                    PH_B:   if (m_nb < MD) begin m_b = (m_b * 10 + code) % (MASK + 1); m_nb++; end
                    PH_RES: begin m_a = code; m_na = 1; m_b = 0; m_err = 0; m_ph = PH_A; end
                endcase
            end
        end else if (op) begin
            if (code >= 1 && code <= 4) begin
                case (m_ph)
                    PH_A:   begin m_op = code; m_ph = PH_OPW; end
                    PH_RES: begin m_a = m_res; m_err = 0; m_op = code; m_ph = PH_OPW; end
                    default: m_op = code;
                endcase
            end else if (code == 14 && m_ph == PH_B) begin
                if (m_op == 4 && m_b == 0) begin
                    m_err = 1; m_res = 0; m_ph = PH_RES;
                end else begin
                    launch = 1;
                end
            end
        end
        return launch;
    endfunction

    // Behavioural ALU: answers every launch after alu_lat cycles unless withheld.
    int alu_lat  = 3;
    bit withhold = 0;
    int l_a, l_b, l_op;
    int start_hi = 0;
    int exp_launches = 0;

    always @(negedge clk) if (alu_start === 1'b1) start_hi++;

    initial begin
        int r;
        bit e;
        alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1) begin
                l_a = operand_a; l_b = operand_b; l_op = alu_op;
                if (!withhold) begin
                    alu_ref(l_a, l_b, l_op, r, e);
                    repeat (alu_lat) @(negedge clk);
                    if (busy === 1'b1) begin
                        check("stable_a", operand_a, l_a);
                        check("stable_b", operand_b, l_b);
                    end
                    alu_done = 1'b1; alu_result = r[DW-1:0]; alu_err = e;
                    @(negedge clk);
                    alu_done = 1'b0; alu_result = DW'($urandom); alu_err = 1'b0;
                end
            end
        end
    end

    task automatic press(input bit dig, input bit op, input int code, input int hold,
                         output bit launch);
        @(negedge clk);
        newDigit = dig; newOp = op; clickedMatrix = code[3:0];
        @(negedge clk);
        launch = m_event(dig, op, code);
        if (launch) exp_launches++;
        check("busy", busy, launch);
        check("alu_start", alu_start, launch);
        check("display", display_value, m_disp());
        check("error", error, m_err);
        check("alu_op", alu_op, m_op);
        repeat (hold - 1) @(negedge clk);
        newDigit = 1'b0; newOp = 1'b0;
    endtask

    task automatic complete_exec();
        int r;
        bit e;
        int n = 0;
        while (busy === 1'b1 && n < TMO + 16) begin
            @(negedge clk);
            n++;
        end
        check("exec_ends", busy, 0);
        alu_ref(m_a, m_b, m_op, r, e);
        check("launch_a", l_a, m_a);
        check("launch_b", l_b, m_b);
        check("launch_op", l_op, m_op);
        m_res = r; m_err = e; m_ph = PH_RES;
        check("result", display_value, m_res);
        check("result_err", error, m_err);
        check("start_pulses", start_hi, exp_launches);
    endtask

    task automatic key(input bit dig, input bit op, input int code, input int hold);
        bit launch;
        press(dig, op, code, hold, launch);
        if (launch) complete_exec();
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        m_reset();
        check("clr_display", display_value, 0);
        check("clr_error", error, 0);
        check("clr_busy", busy, 0);
        check("clr_op", alu_op, 0);
        check("clr_a", operand_a, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, alu_start, 0);
        check({tag, "_op"}, alu_op, 0);
        check({tag, "_a"}, operand_a, 0);
        check({tag, "_b"}, operand_b, 0);
        check({tag, "_display"}, display_value, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        bit launch;
        rst_n = 1'b1; newDigit = 1'b0; newOp = 1'b0; clickedMatrix = '0; clear = 1'b0;
        m_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // 12 + 34 = 46 with a 3-cycle ALU
        alu_lat = 3;
        key(1, 0, 1, 5); key(1, 0, 2, 5);
        check("tp1_a", display_value, 12);
        key(0, 1, 2, 5); key(1, 0, 3, 5); key(1, 0, 4, 5);
        check("tp1_b", display_value, 34);
        s0 = start_hi;
        key(0, 1, 14, 5);
        check("tp1_launches", start_hi, s0 + 1);
        check("tp1_op", l_op, 2);
        check("tp1_opa", l_a, 12);
        check("tp1_opb", l_b, 34);
        check("tp1_result", display_value, 46);

        // long hold is a single event
        do_clear();
        key(1, 0, 7, 50);
        check("hold_once", display_value, 7);
        key(1, 0, 7, 3);
        check("hold_again", display_value, 77);

        // fifth digit ignored
        do_clear();
        key(1, 0, 9, 2); key(1, 0, 8, 2); key(1, 0, 7, 2); key(1, 0, 6, 2); key(1, 0, 5, 2);
        check("max_digits", display_value, 9876);

        // divide by zero never reaches the ALU
        do_clear();
        key(1, 0, 8, 2); key(0, 1, 4, 2); key(1, 0, 0, 2);
        s0 = start_hi;
        key(0, 1, 14, 2);
        check("div0_nostart", start_hi, s0);
        check("div0_error", error, 1);
        check("div0_display", display_value, 0);
        key(1, 0, 3, 2);
        check("div0_recover_err", error, 0);
        check("div0_recover_a", display_value, 3);

        // result chaining: 6*7=42, then 42-2=40
        do_clear();
        key(1, 0, 6, 2); key(0, 1, 1, 2); key(1, 0, 7, 2); key(0, 1, 14, 2);
        check("chain_first", display_value, 42);
        key(0, 1, 3, 2); key(1, 0, 2, 2); key(0, 1, 14, 2);
        check("chain_opa", l_a, 42);
        check("chain_opb", l_b, 2);
        check("chain_op", l_op, 3);
        check("chain_result", display_value, 40);

        // ALU never answers: timeout after exactly TMO cycles, clicks in EXEC dropped
        do_clear();
        withhold = 1;
        key(1, 0, 5, 2); key(0, 1, 2, 2); key(1, 0, 3, 2);
        s0 = start_hi;
        press(0, 1, 14, 1, launch);
        clickedMatrix = 4'd9;
        n = 1;
        for (int k = 0; k < TMO + 20; k++) begin
            @(negedge clk);
            newDigit = (n >= 10 && n < 12);
            if (busy !== 1'b1) break;
            n++;
        end
        newDigit = 1'b0;
        check("tmo_cycles", n, TMO);
        check("tmo_launches", start_hi, s0 + 1);
        check("tmo_error", error, 1);
        check("tmo_display", display_value, 0);
        check("tmo_a_kept", operand_a, 5);
        m_res = 0; m_err = 1; m_ph = PH_RES;

        // reset in the middle of EXEC
        key(1, 0, 1, 2); key(0, 1, 2, 2); key(1, 0, 2, 2);
        s0 = start_hi;
        press(0, 1, 14, 2, launch);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk); rst_n = 1'b1;
        m_reset();
        repeat (10) @(negedge clk);
        check("midreset_norefire", start_hi, s0 + 1);
        check("midreset_busy", busy, 0);
        exp_launches = start_hi;
        withhold = 0;

        // clear in the middle of EXEC; the late alu_done must be ignored
        key(1, 0, 4, 2); key(0, 1, 2, 2); key(1, 0, 4, 2);
        alu_lat = 8;
        press(0, 1, 14, 1, launch);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        m_reset();
        repeat (12) @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_display", display_value, 0);
        check("abort_error", error, 0);
        check("abort_op", alu_op, 0);
        key(1, 0, 5, 2);
        check("abort_enter_a", display_value, 5);

        // random key sequences against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            int code;
            int hold;
            bit d;
            bit o;
            r    = $urandom_range(0, 99);
            hold = $urandom_range(1, 4);
            alu_lat = $urandom_range(1, 6);
            if (r < 3) begin
                do_clear();
            end else begin
                if (r < 50) begin
                    d = 1; o = ($urandom_range(0, 9) == 0);
                    code = $urandom_range(0, 11);
                end else if (r < 80) begin
                    d = 0; o = 1;
                    code = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 13) : $urandom_range(1, 4);
                end else begin
                    d = 0; o = 1; code = 14;
                end
                key(d, o, code, hold);
            end
        end
        check("final_launches", start_hi, exp_launches);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
